// File: rtl/sub_pkg.sv
// sub_pkg: shared constants for the borrow-propagating subtractor slice
package sub_pkg;
    localparam int SUB_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: 1-bit combinational full subtractor (a - b - bin)
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/full_subtractor_design.sv
// full_subtractor_design: ripple-borrow a - b - bin with optional registered output stage
module full_subtractor_design
    import sub_pkg::*;
#(
    parameter int WIDTH   = SUB_DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] d;
    assign br[0] = bin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .bin (br[i]),
            .diff(d[i]),
            .bout(br[i+1])
        );
    end
    if (REG_OUT) begin : g_reg
        // result registers only load on accepted operands; idle cycles hold the last result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                diff      <= '0;
                bout      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    diff <= d;
                    bout <= br[WIDTH];
                end
            end
        end
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk;
        assign diff      = d;
        assign bout      = br[WIDTH];
        assign out_valid = in_valid & rst_n;
    end
endmodule

// File: tb/tb_full_subtractor_design.sv
// tb_full_subtractor_design: scoreboarded random/directed bench for registered and combinational subtractors
module tb_full_subtractor_design;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       v1, a1, b1, c1, d1, bo1, ov1;
    logic       v8, c8, bo8, ov8;
    logic [7:0] a8, b8, d8;
    logic       vc, ac, bc, cc, dc, boc, ovc;

    int checks = 0;
    int errors = 0;
    logic [2:0] q1[$];
    logic [9:0] q8[$];
    logic [1:0] h1;
    logic [8:0] h8;

    full_subtractor_design #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .bin(c1),
        .diff(d1), .bout(bo1), .out_valid(ov1));
    full_subtractor_design #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .bin(c8),
        .diff(d8), .bout(bo8), .out_valid(ov8));
    full_subtractor_design #(.WIDTH(1), .REG_OUT(1'b0)) uc (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .a(ac), .b(bc), .bin(cc),
        .diff(dc), .bout(boc), .out_valid(ovc));

    // reference: plain unsigned arithmetic one bit wider than the operands; top bit is the borrow
    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r = {1'b0, a} - {1'b0, b} - {1'b0, c};
        return r;
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'd0, c};
        return r;
    endfunction

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input logic sv1, input logic sa1, input logic sb1, input logic sc1,
                        input logic sv8, input logic [7:0] sa8, input logic [7:0] sb8, input logic sc8);
        @(negedge clk);
        #1;
        v1 = sv1; a1 = sa1; b1 = sb1; c1 = sc1;
        v8 = sv8; a8 = sa8; b8 = sb8; c8 = sc8;
        if (sv1) h1 = ref1(sa1, sb1, sc1);
        if (sv8) h8 = ref8(sa8, sb8, sc8);
        q1.push_back({sv1, h1});
        q8.push_back({sv8, h8});
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q1.size() > 0) begin
                logic [2:0] e;
                e = q1.pop_front();
                check("u1_valid", 16'(ov1), 16'(e[2]));
                check("u1_result", 16'({bo1, d1}), 16'(e[1:0]));
            end else check("u1_idle_valid", 16'(ov1), 16'd0);
            if (q8.size() > 0) begin
                logic [9:0] e;
                e = q8.pop_front();
                check("u8_valid", 16'(ov8), 16'(e[9]));
                check("u8_result", 16'({bo8, d8}), 16'(e[8:0]));
            end else check("u8_idle_valid", 16'(ov8), 16'd0);
        end
    end

    initial begin
        h1 = '0; h8 = '0;
        rst_n = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h01; c8 = 1'b0;
        vc = 1'b0; ac = 1'b0; bc = 1'b0; cc = 1'b0;
        // load a result at the first edge, then reset asynchronously without a clock
        #7 rst_n = 1'b0;
        #1;
        check("rst_u1", 16'({ov1, bo1, d1}), 16'd0);
        check("rst_u8", 16'({ov8, bo8, d8}), 16'd0);
        v1 = 1'b0; v8 = 1'b0;
        #9 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] t;
            t = 3'(i);
            step(1'b1, t[2], t[1], t[0], 1'b0, 8'h00, 8'h00, 1'b0);
        end
        idle();

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) idle();

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h01, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h0A, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
        idle();

        repeat (20) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                         1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (40) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        idle();

        // reset between accept and capture: pending results must never appear
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 1'b0);
        #2 rst_n = 1'b0;
        q1.delete(); q8.delete();
        h1 = '0; h8 = '0;
        v1 = 1'b0; v8 = 1'b0;
        #1;
        check("midrst_u1", 16'({ov1, bo1, d1}), 16'd0);
        check("midrst_u8", 16'({ov8, bo8, d8}), 16'd0);
        #3 rst_n = 1'b1;
        idle();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0);
        repeat (10) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("drain", 16'(q1.size() + q8.size()), 16'd0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] t;
            t = 3'(i);
            vc = 1'($urandom); ac = t[2]; bc = t[1]; cc = t[0];
            #1;
            check("comb_result", 16'({boc, dc}), 16'(ref1(t[2], t[1], t[0])));
            check("comb_valid", 16'(ovc), 16'(vc));
        end
        vc = 1'b1; ac = 1'b0; bc = 1'b0; cc = 1'b1;
        #1;
        check("comb_001", 16'({ovc, boc, dc}), 16'b111);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("comb_rst_valid", 16'(ovc), 16'd0);
        #1 rst_n = 1'b1;
        #1;
        check("comb_rel_valid", 16'(ovc), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
